spi_txn_arbiter: RTL
====================

// Module: spi_txn_arbiter
// PURPOSE
//  Shares one SPI shift engine among N_REQ requesters, each owning one slave chip-select.
//  Round-robin grants a transfer, frames it with CS setup/hold/gap timing, starts the engine,
//  returns the received word to the granted requester. Sits between AXI-side clients and the SPI engine.
// PARAMETERS
//  N_REQ      4                    number of requesters / chip selects (2..8)
//  DATA_W     32                   max bits per transfer
//  LEN_W      $clog2(DATA_W)+1     width of bit-length fields
//  CS_SETUP   2                    clocks from CS_n low to o_eng_start (0 allowed)
//  CS_HOLD    2                    clocks from done to CS_n high (0 allowed)
//  CS_GAP     4                    min clocks CS_n high before next grant (>=1)
//  TIMEOUT    4096                 watchdog clocks (SPI_ARB_TIMEOUT_EN only)
// PORTS
//  FCLK_CLK0      in   1             clock
//  RST_N          in   1             reset, synchronous, active-low
//  i_req_valid    in   N_REQ         per-requester transfer request
//  i_req_data     in   N_REQ*DATA_W  tx word, requester i at [i*DATA_W +: DATA_W]
//  i_req_len      in   N_REQ*LEN_W   bit count, requester i at [i*LEN_W +: LEN_W]
//  o_req_ready    out  N_REQ         one-hot accept strobe
//  o_rsp_valid    out  N_REQ         one-hot 1-cycle response strobe
//  o_rsp_data     out  DATA_W        rx word, valid with o_rsp_valid
//  o_rsp_err      out  1             timeout flag, valid with o_rsp_valid
//  o_eng_start    out  1             1-cycle engine start pulse
//  o_eng_data     out  DATA_W        tx word to engine (held stable ST_START..ST_WAIT)
//  o_eng_len      out  LEN_W         bit count to engine (held stable ST_START..ST_WAIT)
//  i_eng_busy     in   1             engine busy
//  i_eng_done     in   1             1-cycle transfer-complete pulse
//  i_eng_rx_data  in   DATA_W        rx word, valid with i_eng_done
//  o_cs_n         out  N_REQ         active-low chip selects, at most one low
//  o_busy         out  1             high in every state except ST_IDLE
// BEHAVIOUR
//  Reset (RST_N=0 at clock edge): state ST_IDLE, RR pointer 0, o_cs_n all 1; all strobes,
//   o_busy, o_rsp_err 0; o_rsp_data, o_eng_data, o_eng_len 0. Reset mid-transfer aborts: CS high next edge, no response.
//  FSM: ST_IDLE -> ST_SETUP -> ST_START -> ST_WAIT -> ST_HOLD -> ST_GAP -> ST_IDLE.
//  ST_IDLE: if any i_req_valid, grant g = first valid at or after RR pointer (wrapping).
//   o_req_ready[g]=1 combinationally that cycle. Capture data/len/g. Pointer <= g+1 mod N_REQ.
//   Next cycle o_cs_n[g]=0.
//  Len clamp: captured len 0 or > DATA_W is replaced by DATA_W.
//  ST_SETUP: wait CS_SETUP clocks (skipped when 0).
//  ST_START: if !i_eng_busy, pulse o_eng_start 1 cycle -> ST_WAIT; else stay.
//  ST_WAIT: on i_eng_done, register i_eng_rx_data.
//   Next cycle: o_rsp_valid[g]=1 for 1 cycle, o_rsp_err=0 -> ST_HOLD.
//  ST_HOLD: CS_HOLD clocks, then o_cs_n all 1 -> ST_GAP. ST_GAP: CS_GAP clocks -> ST_IDLE.
//  i_eng_done outside ST_WAIT ignored. Valid dropped before grant: no grant, no error.
//  Simultaneous valids: strict RR. A requester re-asserting right after service waits behind others.
//  Min period per transfer: 1+CS_SETUP+1+engine+1+CS_HOLD+CS_GAP clocks.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined: counter runs in ST_WAIT.
//   At TIMEOUT clocks without done -> o_rsp_valid[g]=1, o_rsp_err=1, o_rsp_data=0 -> ST_HOLD.
//   A late done is then ignored.
//  Undefined: ST_WAIT waits indefinitely; o_rsp_err tied 0; no counter logic.
// STRUCTURE
//  spi_pkg: state encodings ST_IDLE..ST_GAP, default CS timing constants.
//  Sub-module spi_rr_arbiter: N-way round-robin grant (req, pointer -> one-hot grant, index).
//   FSM, timing counters and datapath stay in top.
// TESTING
//  Single req0 data=0xA5A5_0001 len=8, engine echoes 0x5A -> CS0 low 2 clk before start;
//   rsp_valid[0], rsp_data=0x5A; CS0 high 2 clk after.
//  All 4 valid continuously -> grants 0,1,2,3,0 in order;
//   >=CS_GAP clocks of all-CS-high between transfers.
//  len=0 and len=40 -> o_eng_len=32 both.
//  i_eng_busy=1 for 10 clk in ST_START -> start delayed until busy low; exactly one start pulse.
//  RST_N low 3 clk into ST_WAIT -> o_cs_n=all 1 next edge; no rsp_valid; next req granted from requester 0.
//  SPI_ARB_TIMEOUT_EN, TIMEOUT=16, no done -> rsp_valid with rsp_err=1 at 16 clk;
//   late done ignored; next transfer normal.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM state encoding,
// default chip-select timing and a small elaboration-time helper.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  localparam int unsigned DEF_CS_SETUP = 2;
  localparam int unsigned DEF_CS_HOLD  = 2;
  localparam int unsigned DEF_CS_GAP   = 4;
  localparam int unsigned DEF_TIMEOUT  = 4096;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// N-way round-robin grant: first asserted request at or after the pointer,
// wrapping, returned as a one-hot vector plus its index.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_j;

  // Walk the requesters starting at the pointer and stop at the first hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = i_ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_idx        = w_j;
        o_grant[w_j] = 1'b1;
      end
      w_j = (w_j == IDX_W'(N_REQ - 1)) ? '0 : w_j + IDX_W'(1);
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI shift engine among N_REQ requesters, each owning a chip select.
// Round-robin grant, CS setup/hold/gap framing, engine start and response return.
// Optional feature: define SPI_ARB_TIMEOUT_EN to enable the ST_WAIT watchdog
// (response with o_rsp_err=1 after TIMEOUT clocks without i_eng_done).
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LEN_W    = $clog2(DATA_W) + 1,
  parameter int unsigned CS_SETUP = DEF_CS_SETUP,
  parameter int unsigned CS_HOLD  = DEF_CS_HOLD,
  parameter int unsigned CS_GAP   = DEF_CS_GAP,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                    FCLK_CLK0,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  input  logic [N_REQ*LEN_W-1:0]  i_req_len,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [N_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]       o_rsp_data,
  output logic                    o_rsp_err,
  output logic                    o_eng_start,
  output logic [DATA_W-1:0]       o_eng_data,
  output logic [LEN_W-1:0]        o_eng_len,
  input  logic                    i_eng_busy,
  input  logic                    i_eng_done,
  input  logic [DATA_W-1:0]       i_eng_rx_data,
  output logic [N_REQ-1:0]        o_cs_n,
  output logic                    o_busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Sized for the watchdog too so both builds share one counter definition.
  localparam int unsigned CNT_MAX = max_u(max_u(CS_SETUP, CS_HOLD), max_u(CS_GAP, TIMEOUT));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(DATA_W);

  spi_state_e         r_state, w_state_d;
  logic [IDX_W-1:0]   r_ptr, w_ptr_d;
  logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic [DATA_W-1:0]  r_eng_data, w_eng_data_d;
  logic [LEN_W-1:0]   r_eng_len, w_eng_len_d;
  logic [N_REQ-1:0]   r_rsp_valid, w_rsp_valid_d;
  logic [DATA_W-1:0]  r_rsp_data, w_rsp_data_d;

  logic [N_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [DATA_W-1:0]  w_sel_data;
  logic [LEN_W-1:0]   w_sel_len;
  logic [N_REQ-1:0]   w_gnt_onehot;
  logic [N_REQ-1:0]   w_req_ready;
  logic               w_eng_start;
  logic               w_cs_active;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  logic r_rsp_err, w_rsp_err_d;
`endif

  spi_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Select the winning requester's tx word and bit count.
  always_comb begin
    w_sel_data = '0;
    w_sel_len  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_sel_data = i_req_data[i*DATA_W +: DATA_W];
        w_sel_len  = i_req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign w_gnt_onehot = N_REQ'(1) << r_gnt_idx;

  // Transaction FSM next-state, capture and strobe generation.
  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_gnt_idx_d   = r_gnt_idx;
    w_eng_data_d  = r_eng_data;
    w_eng_len_d   = r_eng_len;
    w_rsp_valid_d = '0;
    w_rsp_data_d  = r_rsp_data;
    w_req_ready   = '0;
    w_eng_start   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    w_rsp_err_d   = r_rsp_err;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_req_ready  = w_grant;
          w_gnt_idx_d  = w_idx;
          w_eng_data_d = w_sel_data;
          // Zero or oversize lengths fall back to a full-width transfer.
          w_eng_len_d  = ((w_sel_len == '0) || (w_sel_len > LEN_MAX)) ? LEN_MAX : w_sel_len;
          w_ptr_d      = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
          w_state_d    = (CS_SETUP > 0) ? ST_SETUP : ST_START;
        end
      end
      ST_SETUP: begin
        if (r_cnt == SETUP_LAST) w_state_d = ST_START;
      end
      ST_START: begin
        if (!i_eng_busy) begin
          w_eng_start = 1'b1;
          w_state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_eng_done) begin
          w_rsp_valid_d = w_gnt_onehot;
          w_rsp_data_d  = i_eng_rx_data;
`ifdef SPI_ARB_TIMEOUT_EN
          w_rsp_err_d   = 1'b0;
`endif
          w_state_d     = (CS_HOLD > 0) ? ST_HOLD : ST_GAP;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (r_cnt == TO_LAST) begin
          w_rsp_valid_d = w_gnt_onehot;
          w_rsp_data_d  = '0;
          w_rsp_err_d   = 1'b1;
          w_state_d     = (CS_HOLD > 0) ? ST_HOLD : ST_GAP;
        end
`endif
      end
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) w_state_d = ST_GAP;
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  // Phase counter: restarts on every state change, runs only in timed states.
  always_comb begin
    w_cnt_d = '0;
    if (w_state_d == r_state) begin
      unique case (r_state)
        ST_SETUP, ST_HOLD, ST_GAP: w_cnt_d = r_cnt + CNT_W'(1);
`ifdef SPI_ARB_TIMEOUT_EN
        ST_WAIT:                   w_cnt_d = r_cnt + CNT_W'(1);
`endif
        default:                   w_cnt_d = '0;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge FCLK_CLK0) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_cnt       <= '0;
      r_eng_data  <= '0;
      r_eng_len   <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_gnt_idx   <= w_gnt_idx_d;
      r_cnt       <= w_cnt_d;
      r_eng_data  <= w_eng_data_d;
      r_eng_len   <= w_eng_len_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_data  <= w_rsp_data_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Error flag accompanies the response strobe.
  always_ff @(posedge FCLK_CLK0) begin
    if (!RST_N) r_rsp_err <= 1'b0;
    else        r_rsp_err <= w_rsp_err_d;
  end
  assign o_rsp_err = r_rsp_err;
`else
  assign o_rsp_err = 1'b0;
`endif

  assign w_cs_active = (r_state == ST_SETUP) || (r_state == ST_START) ||
                       (r_state == ST_WAIT)  || (r_state == ST_HOLD);

  assign o_cs_n      = w_cs_active ? ~w_gnt_onehot : '1;
  assign o_req_ready = w_req_ready;
  assign o_eng_start = w_eng_start;
  assign o_eng_data  = r_eng_data;
  assign o_eng_len   = r_eng_len;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_busy      = (r_state != ST_IDLE);

endmodule
